// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch stage. Owns the program counter, issues word reads to
// instruction memory over a req/ack handshake and presents {pc, instruction}
// to decode over a valid/ready handshake. A jump from execute redirects the PC
// and squashes any wrong-path fetch that is in flight or already held.
//
// Optional feature (compile-time macro MISALIGN_TRAP_EN):
//   defined   - a jump whose target has bits [1:0] != 0 redirects to
//               TRAP_VECTOR and pulses misalign_trap for one cycle.
//   undefined - target bits [1:0] are cleared; misalign_trap is tied 0.
//
// Ports:
//   clk, rst_n               clock; synchronous active-low reset
//   jump_flag, jump_target   redirect request from execute (one-cycle pulse)
//   imem_req, imem_addr      fetch request and word address to memory
//   imem_ack, imem_rdata     request accepted, data returned same cycle
//   out_valid, out_ready     handshake towards decode
//   out_pc, out_inst         presented instruction and its PC
//   misalign_trap            pulse on a misaligned redirect
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] NOP_INST    = 32'h0000_0013,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jump_flag,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        misalign_trap
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] redirect_pc, redirect_pc_next;
  logic        discard, discard_next;
  logic [31:0] out_pc_next, out_inst_next;
  logic [31:0] target;

`ifdef MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = |jump_target[1:0];
  assign target     = misaligned ? TRAP_VECTOR : {jump_target[31:2], 2'b00};
`else
  // Low target bits are deliberately ignored when misaligned jumps are not trapped.
  logic unused_target_low;
  assign unused_target_low = ^jump_target[1:0];
  assign target            = {jump_target[31:2], 2'b00};
`endif

  // imem_addr is the PC itself, so it cannot move while a request waits for ack.
  assign imem_req  = (state == S_REQ);
  assign imem_addr = pc;
  // A jump cycle never transfers to decode: the held instruction is wrong-path.
  assign out_valid = (state == S_HOLD) & ~jump_flag;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which is what keeps this block from inferring latches.
    state_next       = state;
    pc_next          = pc;
    redirect_pc_next = redirect_pc;
    discard_next     = discard;
    out_pc_next      = out_pc;
    out_inst_next    = out_inst;

    case (state)
      S_BOOT: begin
        state_next = S_REQ;
        if (jump_flag) pc_next = target;
      end

      S_REQ: begin
        if (imem_ack) begin
          if (jump_flag) begin
            // Returned word is wrong-path; the fresh target supersedes any pending redirect.
            pc_next      = target;
            discard_next = 1'b0;
          end else if (discard) begin
            pc_next      = redirect_pc;
            discard_next = 1'b0;
          end else begin
            out_inst_next = imem_rdata;
            out_pc_next   = pc;
            pc_next       = pc + 32'd4;
            state_next    = S_HOLD;
          end
        end else if (jump_flag) begin
          // The outstanding request must complete at its address; remember
          // to throw its data away and where to go afterwards.
          discard_next     = 1'b1;
          redirect_pc_next = target;
        end
      end

      S_HOLD: begin
        if (jump_flag) begin
          out_inst_next = NOP_INST;
          pc_next       = target;
          state_next    = S_REQ;
        end else if (out_ready) begin
          state_next = S_REQ;
        end
      end

      default: state_next = S_BOOT;
    endcase
  end

  // NOTE: reset is synchronous, so it lives inside the clocked branch and
  // wins over every next-state value, including a concurrent jump.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_BOOT;
      pc          <= RESET_PC;
      redirect_pc <= RESET_PC;
      discard     <= 1'b0;
      out_pc      <= 32'h0000_0000;
      out_inst    <= NOP_INST;
    end else begin
      // NOTE: non-blocking assignments so all state updates see pre-edge values.
      state       <= state_next;
      pc          <= pc_next;
      redirect_pc <= redirect_pc_next;
      discard     <= discard_next;
      out_pc      <= out_pc_next;
      out_inst    <= out_inst_next;
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (!rst_n) misalign_trap <= 1'b0;
    else        misalign_trap <= jump_flag & misaligned;
  end
`else
  assign misalign_trap = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed stimulus for fetch_unit. A transaction-level model tracks the
// address that must be fetched next, the instruction that must be held for
// decode, and whether an in-flight request is wrong-path; one compare process
// checks the DUT against it every cycle. Literal expectations in the stimulus
// pin the model to hand-computed values.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam logic [31:0] NOP_INST    = 32'h0000_0013;
  localparam logic [31:0] TRAP_VECTOR = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        jump_flag = 1'b0;
  logic [31:0] jump_target = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        misalign_trap;

  int errors = 0;
  int checks = 0;

  fetch_unit #(
    .RESET_PC   (RESET_PC),
    .NOP_INST   (NOP_INST),
    .TRAP_VECTOR(TRAP_VECTOR)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .jump_flag    (jump_flag),
    .jump_target  (jump_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_inst     (out_inst),
    .misalign_trap(misalign_trap)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  function automatic logic [31:0] redirect_of(input logic [31:0] t);
    if (TRAP_EN && (t[1:0] != 2'b00)) return TRAP_VECTOR;
    return {t[31:2], 2'b00};
  endfunction

  // ---------------------------------------------------------------- model
  logic        was_reset = 1'b0;
  logic [31:0] m_pc = RESET_PC;     // next address that must be fetched and delivered
  logic        m_held_v = 1'b0;     // an instruction is owed to decode
  logic [31:0] m_held_pc = 32'h0;
  logic [31:0] m_held_inst = 32'h0;
  logic        m_squash = 1'b0;     // outstanding request is wrong-path
  logic [31:0] m_stale = 32'h0;     // address of that wrong-path request
  logic        m_trap = 1'b0;

  always @(posedge clk) was_reset = !rst_n;

  always @(negedge clk) begin
    if (was_reset) begin
      check("rst_imem_req", {31'b0, imem_req}, 32'd0);
      check("rst_imem_addr", imem_addr, RESET_PC);
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_out_pc", out_pc, 32'h0);
      check("rst_out_inst", out_inst, NOP_INST);
      check("rst_trap", {31'b0, misalign_trap}, 32'd0);
      m_pc     = RESET_PC;
      m_held_v = 1'b0;
      m_squash = 1'b0;
    end else begin
      check("trap", {31'b0, misalign_trap}, {31'b0, m_trap});
      check("req_when_not_holding", {31'b0, imem_req}, {31'b0, !m_held_v});
      check("out_valid", {31'b0, out_valid}, {31'b0, m_held_v & !jump_flag});
      if (m_held_v) begin
        check("held_pc", out_pc, m_held_pc);
        check("held_inst", out_inst, m_held_inst);
      end
      if (imem_req) check("fetch_addr", imem_addr, m_squash ? m_stale : m_pc);
    end

    m_trap = rst_n && jump_flag && TRAP_EN && (jump_target[1:0] != 2'b00);

    if (rst_n) begin
      if (jump_flag) begin
        if (imem_req && !imem_ack) begin
          if (!m_squash) m_stale = m_pc;
          m_squash = 1'b1;
        end else if (imem_req) begin
          m_squash = 1'b0;
        end
        m_held_v = 1'b0;
        m_pc     = redirect_of(jump_target);
      end else if (m_held_v) begin
        if (out_ready) m_held_v = 1'b0;
      end else if (imem_req && imem_ack) begin
        if (m_squash) begin
          m_squash = 1'b0;
        end else begin
          m_held_v    = 1'b1;
          m_held_pc   = m_pc;
          m_held_inst = imem_rdata;
          m_pc        = m_pc + 32'd4;
        end
      end
    end
  end

  // ------------------------------------------------------------- stimulus
  // One call = one cycle: inputs change just after the rising edge and the
  // caller's literal checks run at the following falling edge.
  task automatic cyc(input logic r, input logic j, input logic [31:0] t,
                     input logic a, input logic [31:0] d, input logic rdy);
    @(posedge clk);
    #1;
    rst_n       = r;
    jump_flag   = j;
    jump_target = t;
    imem_ack    = a;
    imem_rdata  = d;
    out_ready   = rdy;
    @(negedge clk);
  endtask

  localparam logic [31:0] MIS_PC = TRAP_EN ? 32'h0000_0100 : 32'h0000_0040;

  initial begin
    // Reset for three edges.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h93, 1'b1);
    check("lit_reset_req", {31'b0, imem_req}, 32'd0);
    check("lit_reset_inst", out_inst, 32'h0000_0013);

    // Boot: idle cycle, then fetch at 0, then deliver, then fetch at 4.
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0093, 1'b1);
    check("lit_boot_idle", {31'b0, imem_req}, 32'd0);
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0093, 1'b1);
    check("lit_first_req", {31'b0, imem_req}, 32'd1);
    check("lit_first_addr", imem_addr, 32'h0);
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0093, 1'b1);
    check("lit_first_valid", {31'b0, out_valid}, 32'd1);
    check("lit_first_pc", out_pc, 32'h0);
    check("lit_first_inst", out_inst, 32'h0000_0093);
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'h1111_1111, 1'b1);
    check("lit_second_addr", imem_addr, 32'h4);

    // Backpressure for five cycles.
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'hAAAA_AAAA, 1'b0);
      check("lit_bp_valid", {31'b0, out_valid}, 32'd1);
      check("lit_bp_pc", out_pc, 32'h4);
      check("lit_bp_inst", out_inst, 32'h1111_1111);
      check("lit_bp_noreq", {31'b0, imem_req}, 32'd0);
    end
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'hAAAA_AAAA, 1'b1);

    // Jump while a request at 8 waits; ack comes three cycles later.
    cyc(1'b1, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1);
    check("lit_wait_addr0", imem_addr, 32'h8);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    check("lit_wait_addr2", imem_addr, 32'h8);
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b1);
    check("lit_wait_addr3", imem_addr, 32'h8);
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'h2222_2222, 1'b1);
    check("lit_redirect_addr", imem_addr, 32'h40);

    // Jump in S_HOLD with decode ready.
    cyc(1'b1, 1'b1, 32'h80, 1'b1, 32'h0, 1'b1);
    check("lit_hold_jump_valid", {31'b0, out_valid}, 32'd0);
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'h3333_3333, 1'b1);
    check("lit_hold_jump_addr", imem_addr, 32'h80);
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1);
    check("lit_after_hold_pc", out_pc, 32'h80);
    check("lit_after_hold_inst", out_inst, 32'h3333_3333);

    // PC wrap.
    cyc(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h4444_4444, 1'b1);
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'h5555_5555, 1'b1);
    check("lit_wrap_top", imem_addr, 32'hFFFF_FFFC);
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1);
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'h6666_6666, 1'b1);
    check("lit_wrap_zero", imem_addr, 32'h0);
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1);

    // Misaligned jump.
    cyc(1'b1, 1'b1, 32'h0000_0042, 1'b1, 32'h0, 1'b1);
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'h8888_8888, 1'b1);
    check("lit_mis_addr", imem_addr, MIS_PC);
    check("lit_mis_trap", {31'b0, misalign_trap}, {31'b0, TRAP_EN});
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1);
    check("lit_mis_trap_once", {31'b0, misalign_trap}, 32'd0);

    // Two jumps while waiting: latest target wins.
    cyc(1'b1, 1'b1, 32'h300, 1'b0, 32'h0, 1'b1);
    cyc(1'b1, 1'b1, 32'h400, 1'b0, 32'h0, 1'b1);
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'hBAD0_0BAD, 1'b1);
    check("lit_stale_addr", imem_addr, MIS_PC + 32'd4);
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'h7777_7777, 1'b1);
    check("lit_latest_addr", imem_addr, 32'h400);
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1);
    check("lit_latest_inst", out_inst, 32'h7777_7777);

    // Reset and jump on the same edge.
    cyc(1'b0, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1);
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'h9999_9999, 1'b1);
    check("lit_rj_boot_req", {31'b0, imem_req}, 32'd0);
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'h9999_9999, 1'b1);
    check("lit_rj_addr", imem_addr, RESET_PC);
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1);
    check("lit_rj_inst", out_inst, 32'h9999_9999);
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
